// File: rtl/utils.sv
// Shared definitions for the boot path: system parameters, the instruction BRAM
// write request and the program loader's state encoding and ack bytes.
package utils;

    localparam int CLK_PER_HALF_BIT           = 39;
    localparam int INST_MEM_SIZE              = 16384;
    localparam bit USE_WORD_ADDRESSING_FOR_PC = 1'b0;

    typedef struct packed {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        wenable;
    } bram_wreq_t;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN,
        LD_DATA,
        LD_DONE,
        LD_ERR
    } loader_state_t;

    localparam logic [7:0] ACK_OK  = 8'hAA;
    localparam logic [7:0] ACK_ERR = 8'hEE;

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronises rxd, samples each bit at its middle and
// reports either a received byte or a framing error as a one-cycle pulse.
module uart_rx #(
    parameter int CLK_PER_HALF_BIT = utils::CLK_PER_HALF_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLK_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(2 * CLK_PER_HALF_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shreg, shreg_next;
    logic          valid_next, ferr_next;
    logic          rx_meta, rx_sync, rx_prev;

    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_next = RX_START;
                    cnt_next   = HALF_BIT;
                end
            end
            RX_START: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (!rx_sync) begin
                    state_next   = RX_DATA;
                    cnt_next     = FULL_BIT;
                    bit_idx_next = 3'd0;
                end else begin
                    // Start bit was high again at its middle: a glitch, not a frame.
                    state_next = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    shreg_next = {rx_sync, shreg[7:1]};
                    cnt_next   = FULL_BIT;
                    if (bit_idx == 3'd7) state_next = RX_STOP;
                    else                 bit_idx_next = bit_idx + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    valid_next = rx_sync;
                    ferr_next  = !rx_sync;
                    state_next = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'h00;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rxd;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_idx_next;
            shreg      <= shreg_next;
            byte_valid <= valid_next;
            frame_err  <= ferr_next;
        end
    end

    assign byte_data = shreg;

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed little-endian program over UART and
// writes it word by word into instruction BRAM, then flags done or err.
module program_loader
    import utils::*;
#(
    parameter int CLK_PER_HALF_BIT = utils::CLK_PER_HALF_BIT,
    parameter int INST_MEM_SIZE    = utils::INST_MEM_SIZE,
    parameter bit WORD_ADDR        = utils::USE_WORD_ADDRESSING_FOR_PC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output bram_wreq_t inst_wreq,
    output logic       loading,
    output logic       done,
    output logic       err,
    output logic       ack_valid,
    output logic [7:0] ack_data
);

    localparam logic [31:0] MAX_WORDS = 32'(INST_MEM_SIZE);

    logic          byte_valid, frame_err;
    logic [7:0]    byte_data;

    loader_state_t state, state_next;
    logic [1:0]    byte_cnt;
    logic [31:0]   word_sr, assembled;
    logic [31:0]   len, idx;
    logic          word_done;

    uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    always_comb begin
        assembled = word_sr;
        assembled[{byte_cnt, 3'b000} +: 8] = byte_data;
        word_done = byte_valid && (byte_cnt == 2'd3);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            LD_IDLE: if (byte_valid) state_next = LD_LEN;
            LD_LEN: begin
                if (frame_err) begin
                    state_next = LD_ERR;
                end else if (word_done) begin
                    if (assembled == 32'd0 || assembled > MAX_WORDS) state_next = LD_ERR;
                    else                                             state_next = LD_DATA;
                end
            end
            LD_DATA: begin
                // idx has already advanced past the word being written this cycle.
                if (frame_err)                           state_next = LD_ERR;
                else if (inst_wreq.wenable && idx == len) state_next = LD_DONE;
            end
            LD_DONE: state_next = LD_DONE;
            LD_ERR:  state_next = LD_ERR;
            default: state_next = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LD_IDLE;
            byte_cnt  <= 2'd0;
            word_sr   <= 32'd0;
            len       <= 32'd0;
            idx       <= 32'd0;
            inst_wreq <= '0;
            ack_valid <= 1'b0;
            ack_data  <= 8'h00;
        end else begin
            state             <= state_next;
            inst_wreq.wenable <= 1'b0;
            ack_valid         <= 1'b0;

            if (state_next != state && state_next == LD_DONE) begin
                ack_valid <= 1'b1;
                ack_data  <= ACK_OK;
            end else if (state_next != state && state_next == LD_ERR) begin
                ack_valid <= 1'b1;
                ack_data  <= ACK_ERR;
            end

            if (byte_valid && (state == LD_IDLE || state == LD_LEN || state == LD_DATA)) begin
                word_sr  <= assembled;
                byte_cnt <= byte_cnt + 2'd1;
            end

            if (state == LD_LEN && word_done && state_next == LD_DATA) begin
                len <= assembled;
                idx <= 32'd0;
            end

            if (state == LD_DATA && word_done) begin
                inst_wreq.wenable <= 1'b1;
                inst_wreq.wdata   <= assembled;
                inst_wreq.waddr   <= WORD_ADDR ? idx : (idx << 2);
                idx               <= idx + 32'd1;
            end
        end
    end

    assign loading = (state == LD_LEN) || (state == LD_DATA);
    assign done    = (state == LD_DONE);
    assign err     = (state == LD_ERR);

endmodule
